// File: rtl/act_wb_ctrl_pkg.sv
// Shared widths, write-back entry type and lane-mask constants for the activation write-back path.
package act_wb_ctrl_pkg;

    localparam int N      = 4;
    localparam int W      = 8;
    localparam int CLOG2M = 4;
    localparam int CLOG2W = 3;
    localparam int AW     = CLOG2M + CLOG2W;
    localparam int DW     = N * W;

    // Mask bit j enables data bits [N*j +: N]; the low half-word lives in the low mask bits.
    localparam logic [W-1:0] WB_MASK_LO   = {{(W/2){1'b0}}, {(W/2){1'b1}}};
    localparam logic [W-1:0] WB_MASK_HI   = ~WB_MASK_LO;
    localparam logic [W-1:0] WB_MASK_FULL = '1;

    typedef struct packed {
        logic          bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [W-1:0]  mask;
    } wb_entry_t;

    typedef enum logic [2:0] {
        WB_IDLE,
        WB_PUSH,
        WB_HOLD,
        WB_MERGE,
        WB_SPILL_PUSH,
        WB_SPILL_HOLD,
        WB_FLUSH
    } wb_action_t;

    function automatic wb_entry_t wb_merge(input wb_entry_t held, input wb_entry_t incoming);
        wb_entry_t merged = incoming;
        for (int j = 0; j < W; j++) begin
            if (held.mask[j]) merged.data[N*j +: N] = held.data[N*j +: N];
        end
        merged.mask = held.mask | incoming.mask;
        return merged;
    endfunction

endpackage

// File: rtl/act_wb_ctrl_wb_fifo.sv
// In-order write-back FIFO: two ordered push ports (port 0 lands first), one pop port, free count.
module wb_fifo
    import act_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic                     push0_valid,
    input  wb_entry_t                push0_entry,
    input  logic                     push1_valid,
    input  wb_entry_t                push1_entry,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_cnt
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [1:0]    n_push;

    assign n_push   = {1'b0, push0_valid} + {1'b0, push1_valid};
    assign head     = mem[rd_ptr];
    assign empty    = (count == '0);
    assign free_cnt = (PW+1)'(DEPTH) - count;

    always_ff @(posedge ck) begin
        if (push0_valid) mem[wr_ptr] <= push0_entry;
        if (push1_valid) mem[push0_valid ? wr_ptr + PW'(1) : wr_ptr] <= push1_entry;
    end

    // Pointers wrap naturally modulo DEPTH; overflow is prevented upstream by the stall rule.
    always_ff @(posedge ck) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_push);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count  <= count + (PW+1)'(n_push) - (PW+1)'(pop);
        end
    end

endmodule

// File: rtl/act_wb_ctrl.sv
// Activation write-back controller: input stage, optional half-word coalescing, FIFO drain to two banks.
// Half-word merging and i_flush are enabled by defining ACT_WB_COALESCE_EN.
module act_wb_ctrl
    import act_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          i_wr,
    input  logic          i_wrh,
    input  logic          i_wrh_l_n,
    input  logic          i_ev_odd_n,
    input  logic [AW-1:0] i_even_addr,
    input  logic [AW-1:0] i_odd_addr,
    input  logic [DW-1:0] i_data,
    input  logic          i_flush,
    output logic          o_stall,
    output logic          o_idle,
    output logic          mem_even_we,
    output logic          mem_odd_we,
    output logic [AW-1:0] mem_even_addr,
    output logic [AW-1:0] mem_odd_addr,
    output logic [DW-1:0] mem_even_wdata,
    output logic [DW-1:0] mem_odd_wdata,
    output logic [W-1:0]  mem_even_mask,
    output logic [W-1:0]  mem_odd_mask,
    input  logic          mem_even_rdy,
    input  logic          mem_odd_rdy
);

    localparam int FW = $clog2(DEPTH) + 1;

    logic          s1_valid;
    wb_entry_t     s1_entry;
    logic          p_valid;
    wb_entry_t     p_entry;
    logic          flush_req;
    wb_entry_t     new_entry;
    wb_action_t    action;
    logic          s1_adv;
    logic          accept;
    logic          push0_valid;
    logic          push1_valid;
    wb_entry_t     push0_entry;
    wb_entry_t     push1_entry;
    logic          pop;
    wb_entry_t     head;
    logic          fifo_empty;
    logic [FW-1:0] free_cnt;

    // S1 only moves on when two slots are free, so a spill (P then S1) can always land.
    assign s1_adv  = s1_valid && (free_cnt >= FW'(2));
    assign o_stall = s1_valid && (free_cnt < FW'(2));
    assign accept  = i_wr && !o_stall;
    assign o_idle  = !s1_valid && !p_valid && fifo_empty && !flush_req;

    always_comb begin
        new_entry      = '0;
        new_entry.bank = i_ev_odd_n;
        new_entry.addr = i_ev_odd_n ? i_odd_addr : i_even_addr;
        new_entry.data = i_data;
        new_entry.mask = !i_wrh ? WB_MASK_FULL : (i_wrh_l_n ? WB_MASK_LO : WB_MASK_HI);
    end

`ifdef ACT_WB_COALESCE_EN
    logic s1_half;
    assign s1_half = (s1_entry.mask != WB_MASK_FULL);
`endif

    always_comb begin
        action = WB_IDLE;
        if (s1_adv) begin
`ifdef ACT_WB_COALESCE_EN
            if (!p_valid)
                action = s1_half ? WB_HOLD : WB_PUSH;
            else if (s1_half && p_entry.bank == s1_entry.bank &&
                     p_entry.addr == s1_entry.addr && p_entry.mask != s1_entry.mask)
                action = WB_MERGE;
            else
                action = s1_half ? WB_SPILL_HOLD : WB_SPILL_PUSH;
`else
            action = WB_PUSH;
`endif
        end else if (!s1_valid && flush_req && free_cnt >= FW'(1)) begin
            action = WB_FLUSH;
        end
    end

    always_comb begin
        push0_valid = 1'b0;
        push1_valid = 1'b0;
        push0_entry = s1_entry;
        push1_entry = s1_entry;
        case (action)
            WB_PUSH:       push0_valid = 1'b1;
            WB_MERGE: begin
                push0_valid = 1'b1;
                push0_entry = wb_merge(p_entry, s1_entry);
            end
            WB_SPILL_PUSH: begin
                push0_valid = 1'b1;
                push0_entry = p_entry;
                push1_valid = 1'b1;
            end
            WB_SPILL_HOLD: begin
                push0_valid = 1'b1;
                push0_entry = p_entry;
            end
            WB_FLUSH: begin
                push0_valid = p_valid;
                push0_entry = p_entry;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_entry <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_entry <= new_entry;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

`ifdef ACT_WB_COALESCE_EN
    // The flush request is sticky until the held half-word has actually been committed.
    always_ff @(posedge ck) begin
        if (rst) begin
            p_valid   <= 1'b0;
            p_entry   <= '0;
            flush_req <= 1'b0;
        end else begin
            case (action)
                WB_HOLD, WB_SPILL_HOLD: begin
                    p_valid <= 1'b1;
                    p_entry <= s1_entry;
                end
                WB_MERGE, WB_SPILL_PUSH, WB_FLUSH: p_valid <= 1'b0;
                default: ;
            endcase
            flush_req <= i_flush || (flush_req && action != WB_FLUSH);
        end
    end
`else
    logic flush_unused;
    assign p_valid      = 1'b0;
    assign p_entry      = '0;
    assign flush_req    = 1'b0;
    assign flush_unused = i_flush;
`endif

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .ck          (ck),
        .rst         (rst),
        .push0_valid (push0_valid),
        .push0_entry (push0_entry),
        .push1_valid (push1_valid),
        .push1_entry (push1_entry),
        .pop         (pop),
        .head        (head),
        .empty       (fifo_empty),
        .free_cnt    (free_cnt)
    );

    // Data buses are zeroed when not strobing so the banks never see stale FIFO contents.
    assign mem_even_we    = !fifo_empty && !head.bank;
    assign mem_odd_we     = !fifo_empty && head.bank;
    assign mem_even_addr  = mem_even_we ? head.addr : '0;
    assign mem_odd_addr   = mem_odd_we  ? head.addr : '0;
    assign mem_even_wdata = mem_even_we ? head.data : '0;
    assign mem_odd_wdata  = mem_odd_we  ? head.data : '0;
    assign mem_even_mask  = mem_even_we ? head.mask : '0;
    assign mem_odd_mask   = mem_odd_we  ? head.mask : '0;
    assign pop            = (mem_even_we && mem_even_rdy) || (mem_odd_we && mem_odd_rdy);

endmodule

// File: tb/tb_act_wb_ctrl.sv
// Bench for act_wb_ctrl: directed scenarios plus random traffic against an ordered expected-write queue.
module tb_act_wb_ctrl;
    import act_wb_ctrl_pkg::*;

    logic          ck = 1'b0;
    logic          rst = 1'b1;
    logic          i_wr = 1'b0, i_wrh = 1'b0, i_wrh_l_n = 1'b0, i_ev_odd_n = 1'b0;
    logic [AW-1:0] i_even_addr = '0, i_odd_addr = '0;
    logic [DW-1:0] i_data = '0;
    logic          i_flush = 1'b0;
    logic          o_stall, o_idle;
    logic          mem_even_we, mem_odd_we;
    logic [AW-1:0] mem_even_addr, mem_odd_addr;
    logic [DW-1:0] mem_even_wdata, mem_odd_wdata;
    logic [W-1:0]  mem_even_mask, mem_odd_mask;
    logic          mem_even_rdy = 1'b1, mem_odd_rdy = 1'b1;

    typedef struct {
        bit            odd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [W-1:0]  mask;
    } wr_t;

    wr_t exp_q[$];
    wr_t pend;
    bit  pend_v = 0;
    bit  rand_rdy = 0;
    bit  saw_stall = 0;
    int  n_compared = 0;
    int  n_mismatched = 0;

    act_wb_ctrl #(.DEPTH(4)) dut (
        .ck(ck), .rst(rst), .i_wr(i_wr), .i_wrh(i_wrh), .i_wrh_l_n(i_wrh_l_n),
        .i_ev_odd_n(i_ev_odd_n), .i_even_addr(i_even_addr), .i_odd_addr(i_odd_addr),
        .i_data(i_data), .i_flush(i_flush), .o_stall(o_stall), .o_idle(o_idle),
        .mem_even_we(mem_even_we), .mem_odd_we(mem_odd_we),
        .mem_even_addr(mem_even_addr), .mem_odd_addr(mem_odd_addr),
        .mem_even_wdata(mem_even_wdata), .mem_odd_wdata(mem_odd_wdata),
        .mem_even_mask(mem_even_mask), .mem_odd_mask(mem_odd_mask),
        .mem_even_rdy(mem_even_rdy), .mem_odd_rdy(mem_odd_rdy)
    );

    always #5 ck = ~ck;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane_mask(input logic [W-1:0] m);
        logic [DW-1:0] lm = '0;
        for (int j = 0; j < W; j++) lm[N*j +: N] = {N{m[j]}};
        return lm;
    endfunction

    // Reference: each accepted request either becomes a write or (when merging) pairs with a held half.
    function automatic void model_accept(input bit odd, input logic [AW-1:0] addr,
                                         input logic [DW-1:0] data, input logic [W-1:0] mask);
        wr_t cur;
        cur.odd = odd; cur.addr = addr; cur.data = data; cur.mask = mask;
`ifdef ACT_WB_COALESCE_EN
        if (mask == 8'hFF) begin
            if (pend_v) exp_q.push_back(pend);
            pend_v = 0;
            exp_q.push_back(cur);
        end else if (!pend_v) begin
            pend = cur; pend_v = 1;
        end else if (pend.odd == odd && pend.addr == addr && pend.mask != mask) begin
            wr_t m = cur;
            m.data = (pend.mask == 8'h0F) ? {data[31:16], pend.data[15:0]}
                                          : {pend.data[31:16], data[15:0]};
            m.mask = 8'hFF;
            exp_q.push_back(m);
            pend_v = 0;
        end else begin
            exp_q.push_back(pend);
            pend = cur;
        end
`else
        exp_q.push_back(cur);
`endif
    endfunction

    function automatic void model_flush();
`ifdef ACT_WB_COALESCE_EN
        if (pend_v) exp_q.push_back(pend);
        pend_v = 0;
`endif
    endfunction

    task automatic tick();
        @(posedge ck);
        #1;
        if (rand_rdy) begin
            mem_even_rdy = 1'($urandom_range(0, 1));
            mem_odd_rdy  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic apply_stimulus(input bit wrh, input bit low, input bit odd,
                                  input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int n = 0;
        logic [W-1:0] m;
        i_wr = 1; i_wrh = wrh; i_wrh_l_n = low; i_ev_odd_n = odd; i_data = data;
        i_odd_addr  = odd ? addr : AW'($urandom);
        i_even_addr = odd ? AW'($urandom) : addr;
        while (o_stall && n < 500) begin
            saw_stall = 1;
            tick();
            n++;
        end
        if (o_stall) check_output("stall_timeout", o_stall, 0);
        m = !wrh ? 8'hFF : (low ? 8'h0F : 8'hF0);
        model_accept(odd, addr, data, m);
        tick();
        i_wr = 0;
    endtask

    task automatic do_flush();
        i_flush = 1;
        model_flush();
        tick();
        i_flush = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!o_idle && n < 400) begin
            tick();
            n++;
        end
        check_output({tag, "_idle"}, o_idle, 1);
        check_output({tag, "_drained"}, exp_q.size(), 0);
    endtask

    // Every write the banks accept is matched in order against the expected queue.
    initial begin
        wr_t e;
        bit  g_odd;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_data, lm;
        logic [W-1:0]  g_mask;
        forever begin
            @(negedge ck);
            if (!rst && ((mem_even_we && mem_even_rdy) || (mem_odd_we && mem_odd_rdy))) begin
                check_output("one_bank", mem_even_we & mem_odd_we, 0);
                if (exp_q.size() == 0) begin
                    check_output("spurious_we", {mem_even_we, mem_odd_we}, 0);
                end else begin
                    e = exp_q.pop_front();
                    g_odd  = mem_odd_we;
                    g_addr = g_odd ? mem_odd_addr  : mem_even_addr;
                    g_data = g_odd ? mem_odd_wdata : mem_even_wdata;
                    g_mask = g_odd ? mem_odd_mask  : mem_even_mask;
                    lm = lane_mask(e.mask);
                    check_output("wr_bank", g_odd, e.odd);
                    check_output("wr_addr", g_addr, e.addr);
                    check_output("wr_mask", g_mask, e.mask);
                    check_output("wr_data", g_data & lm, e.data & lm);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick(); tick();
        rst = 0;
        check_output("rst_idle", o_idle, 1);
        check_output("rst_stall", o_stall, 0);
        check_output("rst_we", {mem_even_we, mem_odd_we}, 0);
        check_output("rst_bus", {mem_even_addr, mem_odd_addr, mem_even_mask, mem_odd_mask}, 0);

        $display("[TB] full write latency");
        apply_stimulus(0, 0, 0, 7'd5, 32'h12345678);
        check_output("lat_early_we", mem_even_we, 0);
        tick();
        check_output("lat_we", mem_even_we, 1);
        check_output("lat_odd_we", mem_odd_we, 0);
        check_output("lat_addr", mem_even_addr, 5);
        check_output("lat_mask", mem_even_mask, 8'hFF);
        check_output("lat_data", mem_even_wdata, 32'h12345678);
        tick();
        check_output("lat_done_we", mem_even_we, 0);
        wait_idle("lat");

        $display("[TB] half pair odd 12");
        apply_stimulus(1, 1, 1, 7'd12, 32'hAAAA5555);
        apply_stimulus(1, 0, 1, 7'd12, 32'h3C3CC3C3);
        do_flush();
        wait_idle("pair");

        $display("[TB] half then full ordering");
        apply_stimulus(1, 1, 1, 7'd3, 32'h0000BEEF);
        apply_stimulus(0, 0, 0, 7'd7, 32'hCAFEF00D);
        do_flush();
        wait_idle("order");

        $display("[TB] backpressure on even bank");
        mem_even_rdy = 0;
        saw_stall = 0;
        fork
            for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 0, AW'(20 + i), 32'h1000 + i);
            begin
                repeat (15) @(posedge ck);
                #1 mem_even_rdy = 1;
            end
        join
        check_output("bp_stall_seen", saw_stall, 1);
        wait_idle("bp");

        $display("[TB] single half with flush");
        apply_stimulus(1, 1, 0, 7'd9, 32'h89ABCDEF);
        do_flush();
        wait_idle("flush");

        $display("[TB] random traffic");
        rand_rdy = 1;
        for (int i = 0; i < 200; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_rdy = 0;
        mem_even_rdy = 1; mem_odd_rdy = 1;
        do_flush();
        wait_idle("rand");

        $display("[TB] reset during drain");
        mem_even_rdy = 0; mem_odd_rdy = 0;
        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, AW'(1 + i), 32'h5000 + i);
        tick(); tick();
        rst = 1;
        exp_q.delete();
        pend_v = 0;
        tick();
        rst = 0;
        check_output("rr_idle", o_idle, 1);
        check_output("rr_stall", o_stall, 0);
        check_output("rr_we", {mem_even_we, mem_odd_we}, 0);
        check_output("rr_bus", {mem_even_addr, mem_even_wdata, mem_even_mask}, 0);
        mem_even_rdy = 1; mem_odd_rdy = 1;
        for (int i = 0; i < 6; i++) begin
            check_output("rr_quiet_we", {mem_even_we, mem_odd_we}, 0);
            tick();
        end
        check_output("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/act_wb_ctrl.md
# act_wb_ctrl

Activation write-back controller: the memory-side consumer of the datapath result stream (`o_data`, `o_data_wr`, `o_data_wrh`, `o_data_wrh_l_n`, `o_data_ev_odd_n`, even/odd addresses). It merges half-word result writes into full words, buffers them in a small FIFO, and drains them in order to the even and odd activation banks with per-lane write masks and per-bank ready backpressure. It sits between `dp` and the banked activation SRAMs, replacing the ideal always-ready memory model.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- N, W, CLOG2M, CLOG2W: taken from `globals_sv`; word = N*W bits, W lanes of N bits, lane k at bits [N*W-1-N*k -: N]
- ck  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_wr  in  1  write request (`o_data_wr`)
- i_wrh  in  1  1 = half-word write, 0 = full word
- i_wrh_l_n  in  1  half select: 1 = low half (bits [N*W/2-1:0]), 0 = high half
- i_ev_odd_n  in  1  1 = odd bank, 0 = even bank
- i_even_addr, i_odd_addr  in  CLOG2M+CLOG2W  bank addresses
- i_data  in  N*W  result word
- i_flush  in  1  pulse: commit any held half-word
- o_stall  out  1  request not accepted this cycle
- o_idle  out  1  nothing buffered
- mem_even_we, mem_odd_we  out  1  bank write strobe
- mem_even_addr, mem_odd_addr  out  CLOG2M+CLOG2W  write address
- mem_even_wdata, mem_odd_wdata  out  N*W  write data
- mem_even_mask, mem_odd_mask  out  W  lane enables, bit W-1 = lane 0 (MSB lane)
- mem_even_rdy, mem_odd_rdy  in  1  bank accepts write this cycle

## Operation
- Accept: i_wr & !o_stall loads input stage S1 (bank, selected address, data, mask). Full → mask all ones; low half → lower W/2 mask bits; high half → upper W/2.
- o_stall = S1 valid & FIFO free slots < 2. S1 advances only when free ≥ 2; a new request may load S1 in the same cycle it advances.
- Coalescing (pending register P, one half-word):
  - S1 half, P empty → S1 to P.
  - S1 half, P same bank+address, opposite half → push merged entry (OR of masks, lanes from each) , P cleared.
  - S1 mismatching P (different bank/address, same half, or full) → push P, then S1 (full: pushed; half: into P). Two pushes in one cycle, P first.
  - S1 full, P empty → push S1.
- Flush: i_flush sets a sticky request; P pushed the first cycle S1 is empty and free ≥ 1; request clears.
- Drain: head entry drives its bank's we/addr/wdata/mask combinationally; other bank we=0. Pop when that bank's rdy=1. Strict order; head blocked on rdy blocks both banks.
- o_idle = S1, P, FIFO all empty, flush request clear.

## Timing
- Reset: all outputs 0 except o_idle=1; S1, P, FIFO, flush flag cleared. Reset mid-operation discards buffered writes; no write strobe in the cycle after reset release.
- Latency: full write accepted at edge k → mem_*_we high in the cycle following edge k+1; written at edge k+2 if rdy=1.
- Half pair: second half accepted at edge k → merged write visible after edge k+1.
- FIFO count pointer wrap modulo DEPTH; no overflow possible by the stall rule; pop on empty never occurs.
- Simultaneous push and pop: count changes by pushes−pops.

## Configuration
- ACT_WB_COALESCE_EN defined: P register and merging as above.
- Undefined: no P; every half-word pushed as its own masked entry; i_flush ignored (o_idle still valid); stall rule unchanged.

## Structure
- `globals_sv`: N, W, CLOG2M, CLOG2W, plus new `wb_entry_t` struct (bank, addr, data, mask) and `WB_MASK_LO`/`WB_MASK_HI` constants.
- One sub-module: `wb_fifo` (DEPTH entries of `wb_entry_t`, 2 push ports ordered, 1 pop port, free count).

## Test plan
- Full write even bank addr 5, data 32'h12345678, rdy=1 → mem_even_we one cycle, addr 5, mask 8'hFF, two edges after acceptance.
- Low half then high half, odd addr 12, back-to-back → (COALESCE_EN) one odd write, mask 8'hFF, merged data; (without) two writes masks 8'h0F then 8'hF0.
- Low half odd addr 3, then full even addr 7 → odd write mask 8'h0F precedes even write mask 8'hFF.
- mem_even_rdy=0, six consecutive full writes, DEPTH=4 → o_stall asserts, no write lost; after rdy=1 all six written in order.
- Single low half to even addr 9, then i_flush → write mask 8'h0F issued, o_idle returns to 1.
- rst during drain with 3 entries queued → all outputs zero next cycle, o_idle=1, no further writes.
